mul_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one registered unsigned A_W×B_W multiplier among N_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the shared multiply stage. It returns the product with the winner's ID on a single valid/ready result port. It sits between the requesting units and the multiplier datapath.

---
 rtl/mul_arbiter.sv | 154 +++++++++++++++
 tb/tb_mul_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one registered unsigned multiplier among
// N_REQ requesters and returns each product with the winning requester's ID.
module mul_arbiter #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned B_W   = 3,
  parameter int unsigned C_W   = A_W + B_W,
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*A_W-1:0]   req_a,
  input  logic [N_REQ*B_W-1:0]   req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  output logic [C_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [A_W-1:0]  a_q, a_d;
  logic [B_W-1:0]  b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic            res_valid_q, res_valid_d;
  logic [C_W-1:0]  res_data_q, res_data_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic            busy_q, busy_d;

  logic [ID_W-1:0] win_c;
  logic            found_c;
  logic            accept_c;
  logic [A_W-1:0]  a_sel_c;
  logic [B_W-1:0]  b_sel_c;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_c   = ID_W'(0);
    found_c = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last_grant_q) + k) % N_REQ;
      if (!found_c && req_valid[ID_W'(cand)]) begin
        found_c = 1'b1;
        win_c   = ID_W'(cand);
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (32'(win_c) == i) begin
        a_sel_c = req_a[i*A_W +: A_W];
        b_sel_c = req_b[i*B_W +: B_W];
      end
    end
  end

  // Grant is only offered while idle or while the pending result drains.
  always_comb begin
    accept_c  = found_c && ((state_q == IDLE) || ((state_q == DONE) && res_ready));
    req_ready = '0;
    if (accept_c) begin
      req_ready[win_c] = 1'b1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = MUL;
        end
      end
      MUL: begin
        res_data_d  = C_W'(a_q) * C_W'(b_q);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = accept_c ? MUL : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_c) begin
      a_d          = a_sel_c;
      b_d          = b_sel_c;
      id_d         = win_c;
      last_grant_d = win_c;
    end

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      busy_q       <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 4;
  localparam int BW = 3;
  localparam int CW = 7;

  logic              sysclk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic [CW-1:0]     res_data;
  logic [1:0]        res_id;
  logic              res_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mul_arbiter dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // Reference model: an accepted operation spends one cycle in flight, then
  // its product sits on the result port until it is consumed.
  int m_last;
  bit m_inflight;
  bit m_rv;
  int m_rd, m_rid;
  int m_oa, m_ob, m_oid;

  task automatic model_reset();
    m_last = N - 1;
    m_inflight = 0;
    m_rv = 0;
    m_rd = 0;
    m_rid = 0;
  endtask

  function automatic logic [N-1:0] m_grant_vec();
    logic [N-1:0] g;
    bit found;
    g = '0;
    found = 0;
    if (!m_inflight && (!m_rv || res_ready)) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (!found && req_valid[i]) begin
          g[i] = 1'b1;
          found = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_edge();
    logic [N-1:0] g;
    g = m_grant_vec();
    if (m_inflight) begin
      m_rv = 1;
      m_rd = m_oa * m_ob;
      m_rid = m_oid;
      m_inflight = 0;
    end else if (m_rv && res_ready) begin
      m_rv = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_inflight = 1;
        m_oa = int'(req_a[i*AW +: AW]);
        m_ob = int'(req_b[i*BW +: BW]);
        m_oid = i;
        m_last = i;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge sysclk);
      checks++;
      if (res_valid !== 1'b0 || res_data !== '0 || res_id !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc %0d got v=%b d=%0d id=%0d exp 0/0/0", c, res_valid, res_data, res_id);
      end
      checks++;
      if (busy !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL reset_busy cyc %0d got busy=%b rr=%b exp 0/0000", c, busy, req_ready);
      end
      next_cycle();
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0010;
    req_a[1*AW +: AW] = 4'd15;
    req_b[1*BW +: BW] = 3'd7;
    res_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      logic [N-1:0] exp_rr;
      logic exp_rv;
      @(negedge sysclk);
      exp_rr = (c == 0) ? 4'b0010 : 4'b0000;
      exp_rv = (c == 2);
      checks++;
      if (req_ready !== exp_rr) begin
        errors++;
        $display("FAIL single_ready cyc %0d got %b exp %b", c, req_ready, exp_rr);
      end
      checks++;
      if (res_valid !== exp_rv) begin
        errors++;
        $display("FAIL single_valid cyc %0d got %b exp %b", c, res_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (res_data !== 7'd105 || res_id !== 2'd1) begin
          errors++;
          $display("FAIL single_result got d=%0d id=%0d exp d=105 id=1", res_data, res_id);
        end
      end
      next_cycle();
      req_valid = '0;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    req_a = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b = {3'd3, 3'd2, 3'd1, 3'd0};
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] exp_rr;
      logic exp_rv;
      @(negedge sysclk);
      exp_rr = (c % 2 == 0) ? 4'(1 << ((c / 2) % N)) : 4'b0000;
      exp_rv = (c >= 2) && (c % 2 == 0);
      checks++;
      if (req_ready !== exp_rr) begin
        errors++;
        $display("FAIL rr_grant cyc %0d got %b exp %b", c, req_ready, exp_rr);
      end
      checks++;
      if (res_valid !== exp_rv) begin
        errors++;
        $display("FAIL rr_valid cyc %0d got %b exp %b", c, res_valid, exp_rv);
      end
      if (exp_rv) begin
        int k;
        k = c / 2 - 1;
        checks++;
        if (res_data !== 7'((k + 1) * k) || res_id !== 2'(k)) begin
          errors++;
          $display("FAIL rr_result cyc %0d got d=%0d id=%0d exp d=%0d id=%0d", c, res_data, res_id, (k + 1) * k, k);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b1000;
    req_a[3*AW +: AW] = 4'd6;
    req_b[3*BW +: BW] = 3'd5;
    res_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] exp_rr;
      logic exp_rv;
      int exp_d;
      if (c == 1) begin
        req_a[3*AW +: AW] = 4'd11;
        req_b[3*BW +: BW] = 3'd3;
      end
      if (c == 7) res_ready = 1'b1;
      if (c == 8) req_valid = '0;
      @(negedge sysclk);
      exp_rr = (c == 0 || c == 7) ? 4'b1000 : 4'b0000;
      exp_rv = (c >= 2 && c <= 7) || (c == 9);
      exp_d  = (c == 9) ? 33 : 30;
      checks++;
      if (req_ready !== exp_rr) begin
        errors++;
        $display("FAIL bp_ready cyc %0d got %b exp %b", c, req_ready, exp_rr);
      end
      checks++;
      if (res_valid !== exp_rv) begin
        errors++;
        $display("FAIL bp_valid cyc %0d got %b exp %b", c, res_valid, exp_rv);
      end
      if (exp_rv) begin
        checks++;
        if (res_data !== 7'(exp_d) || res_id !== 2'd3) begin
          errors++;
          $display("FAIL bp_result cyc %0d got d=%0d id=%0d exp d=%0d id=3", c, res_data, res_id, exp_d);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    int exp_win [5] = '{0, 0, 2, 0, 2};
    do_reset();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      logic [N-1:0] exp_rr;
      if (c == 3) req_valid = 4'b0101;
      @(negedge sysclk);
      exp_rr = (c % 2 == 0) ? 4'(1 << exp_win[c / 2]) : 4'b0000;
      checks++;
      if (req_ready !== exp_rr) begin
        errors++;
        $display("FAIL fair_grant cyc %0d got %b exp %b", c, req_ready, exp_rr);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0100;
    req_a[2*AW +: AW] = 4'd9;
    req_b[2*BW +: BW] = 3'd5;
    req_a[0 +: AW] = 4'd3;
    req_b[0 +: BW] = 3'd4;
    res_ready = 1'b1;
    @(negedge sysclk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant got %b exp 0100", req_ready);
    end
    next_cycle();
    req_valid = '0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_in_reset cyc %0d got v=%b busy=%b exp 0/0", c, res_valid, busy);
      end
      next_cycle();
    end
    rst = 1'b1;
    req_valid = 4'b0101;
    @(negedge sysclk);
    checks++;
    if (req_ready !== 4'b0001 || busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got rr=%b busy=%b v=%b exp 0001/0/0", req_ready, busy, res_valid);
    end
    next_cycle();
    req_valid = '0;
    @(negedge sysclk);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_stale got v=%b exp 0", res_valid);
    end
    next_cycle();
    @(negedge sysclk);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 7'd12 || res_id !== 2'd0) begin
      errors++;
      $display("FAIL mid_result got v=%b d=%0d id=%0d exp 1/12/0", res_valid, res_data, res_id);
    end
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] exp_rr;
      req_valid = 4'($urandom_range(0, 15));
      req_a = 16'($urandom);
      req_b = 12'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge sysclk);
      exp_rr = m_grant_vec();
      checks++;
      if (req_ready !== exp_rr) begin
        errors++;
        $display("FAIL rnd_ready cyc %0d got %b exp %b", c, req_ready, exp_rr);
      end
      checks++;
      if (res_valid !== m_rv) begin
        errors++;
        $display("FAIL rnd_valid cyc %0d got %b exp %b", c, res_valid, m_rv);
      end
      checks++;
      if (busy !== (m_inflight || m_rv)) begin
        errors++;
        $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy, (m_inflight || m_rv));
      end
      if (m_rv) begin
        checks++;
        if (res_data !== 7'(m_rd) || res_id !== 2'(m_rid)) begin
          errors++;
          $display("FAIL rnd_result cyc %0d got d=%0d id=%0d exp d=%0d id=%0d", c, res_data, res_id, m_rd, m_rid);
        end
      end
      model_edge();
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
